// File: rtl/ahb_bus_monitor.sv
// Passive AHB master-port monitor: burst tracking FSM, coded violation reports
// and saturating read/write/busy statistics. Never drives the bus.
module ahb_bus_monitor #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic              HREADY,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [1:0]        HRESP,
   input  logic              HGRANT,
   input  logic              HLOCK,
   input  logic              clr_cnt,
   output logic              err_valid,
   output logic [3:0]        err_code,
   output logic [ADDR_W-1:0] err_addr,
   output logic [7:0]        err_sticky,
   output logic              burst_active,
   output logic [4:0]        beat_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  busy_cnt
);

   localparam int unsigned SIZE_MAX = $clog2(DATA_W / 8);
   localparam logic [1:0]  TR_IDLE   = 2'd0;
   localparam logic [1:0]  TR_BUSY   = 2'd1;
   localparam logic [1:0]  TR_NONSEQ = 2'd2;
   localparam logic [1:0]  TR_SEQ    = 2'd3;
   localparam logic [1:0]  RESP_OKAY = 2'd0;
   localparam logic [2:0]  BURST_SINGLE = 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR1} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  lat_addr_q;
   logic [2:0]         lat_size_q;
   logic [2:0]         lat_burst_q;
   logic               lat_write_q;
   logic               prev_wait_q;
   logic [1:0]         prev_trans_q;
   logic [ADDR_W-1:0]  prev_addr_q;
   logic               prev_write_q;
   logic [2:0]         prev_size_q;
   logic [2:0]         prev_burst_q;

   logic               active, accepted, is_idle, is_busy, is_nonseq, is_seq, resp_err;
   logic [4:0]         lat_len, beat_inc;
   logic               lat_fixed, lat_wrap;
   logic [ADDR_W-1:0]  bytes, wrap_mask, inc_addr, exp_addr;
   logic [7:0]         codes;
   logic [3:0]         code_d;
   logic               unused_lock;

   assign unused_lock = HLOCK;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: burst_len = 5'd4;
         3'd4, 3'd5: burst_len = 5'd8;
         3'd6, 3'd7: burst_len = 5'd16;
         default:    burst_len = 5'd0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      sat_inc = (c == '1) ? c : c + CNT_W'(1);
   endfunction

   // Violation decode and next-state logic
   always_comb begin
      state_d   = state_q;
      codes     = '0;
      code_d    = 4'd0;
      active    = HTRANS[1];
      accepted  = active && HREADY;
      is_idle   = (HTRANS == TR_IDLE);
      is_busy   = (HTRANS == TR_BUSY);
      is_nonseq = (HTRANS == TR_NONSEQ);
      is_seq    = (HTRANS == TR_SEQ);
      resp_err  = (HRESP != RESP_OKAY);
      lat_len   = burst_len(lat_burst_q);
      lat_fixed = (lat_len != 5'd0);
      lat_wrap  = lat_fixed && !lat_burst_q[0];
      beat_inc  = (beat_cnt == 5'h1F) ? beat_cnt : beat_cnt + 5'd1;
      bytes     = ADDR_W'(1) << lat_size_q;
      wrap_mask = (ADDR_W'(lat_len) << lat_size_q) - ADDR_W'(1);
      inc_addr  = lat_addr_q + bytes;
      exp_addr  = lat_wrap ? ((lat_addr_q & ~wrap_mask) | (inc_addr & wrap_mask)) : inc_addr;

      codes[0] = HREADY && is_seq  && (state_q == S_IDLE);
      codes[1] = HREADY && is_busy && (state_q == S_IDLE);
      codes[2] = HREADY && is_seq  && (HADDR != exp_addr);
      codes[3] = HREADY && (is_seq || is_busy) &&
                 ((HWRITE != lat_write_q) || (HSIZE != lat_size_q) || (HBURST != lat_burst_q));
      // A stalled transfer may only be abandoned during a two-cycle error response
      codes[4] = prev_wait_q && (state_q != S_ERR1) &&
                 ((HTRANS != prev_trans_q) || (HADDR != prev_addr_q) || (HWRITE != prev_write_q) ||
                  (HSIZE != prev_size_q) || (HBURST != prev_burst_q));
      codes[5] = HREADY && (state_q == S_BURST) && lat_fixed && (beat_cnt < lat_len) &&
                 (is_idle || is_nonseq) && !resp_err && HGRANT;
      codes[6] = (resp_err && HREADY && (state_q != S_ERR1)) || ((state_q == S_ERR1) && !resp_err);
      codes[7] = (accepted && (HSIZE > 3'(SIZE_MAX))) ||
                 (HREADY && is_seq && lat_fixed && (beat_cnt >= lat_len));

      for (int i = 7; i >= 0; i--) begin
         if (codes[i]) code_d = 4'(i + 1);
      end

      if (resp_err && !HREADY) begin
         state_d = S_ERR1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accepted && is_nonseq && (HBURST != BURST_SINGLE)) state_d = S_BURST;
            end
            S_BURST: begin
               if (HREADY) begin
                  if (is_nonseq)
                     state_d = (HBURST != BURST_SINGLE) ? S_BURST : S_IDLE;
                  else if (is_idle)
                     state_d = S_IDLE;
                  else if (is_seq && lat_fixed && (beat_inc >= lat_len))
                     state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q      <= S_IDLE;
         burst_active <= 1'b0;
         err_valid    <= 1'b0;
         err_code     <= 4'd0;
         err_addr     <= '0;
         err_sticky   <= 8'd0;
         beat_cnt     <= 5'd0;
         lat_addr_q   <= '0;
         lat_size_q   <= 3'd0;
         lat_burst_q  <= 3'd0;
         lat_write_q  <= 1'b0;
         prev_wait_q  <= 1'b0;
         prev_trans_q <= 2'd0;
         prev_addr_q  <= '0;
         prev_write_q <= 1'b0;
         prev_size_q  <= 3'd0;
         prev_burst_q <= 3'd0;
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         busy_cnt     <= '0;
      end else begin
         state_q      <= state_d;
         burst_active <= (state_d == S_BURST);
         err_valid    <= |codes;
         err_sticky   <= err_sticky | codes;
         if (|codes) begin
            err_code <= code_d;
            err_addr <= HADDR;
         end

         prev_wait_q  <= active && !HREADY;
         prev_trans_q <= HTRANS;
         prev_addr_q  <= HADDR;
         prev_write_q <= HWRITE;
         prev_size_q  <= HSIZE;
         prev_burst_q <= HBURST;

         // Burst context follows the last accepted beat
         if (accepted && is_nonseq) begin
            lat_addr_q  <= HADDR;
            lat_size_q  <= HSIZE;
            lat_burst_q <= HBURST;
            lat_write_q <= HWRITE;
            beat_cnt    <= 5'd1;
         end else if (accepted && is_seq && (state_q == S_BURST)) begin
            lat_addr_q <= HADDR;
            beat_cnt   <= beat_inc;
         end

         if (clr_cnt) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            busy_cnt <= '0;
         end else begin
            if (accepted && HWRITE)    wr_cnt   <= sat_inc(wr_cnt);
            if (accepted && !HWRITE)   rd_cnt   <= sat_inc(rd_cnt);
            if (is_busy && HREADY)     busy_cnt <= sat_inc(busy_cnt);
         end
      end
   end

endmodule

// File: tb/tb_ahb_bus_monitor.sv
// Scoreboard bench for ahb_bus_monitor: each driven cycle pushes its expected
// error report, popped and compared one edge later.
module tb_ahb_bus_monitor;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic              HCLK = 1'b0;
   logic              HRESETn;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic              HREADY;
   logic [ADDR_W-1:0] HADDR;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [1:0]        HRESP;
   logic              HGRANT;
   logic              HLOCK;
   logic              clr_cnt;
   logic              err_valid;
   logic [3:0]        err_code;
   logic [ADDR_W-1:0] err_addr;
   logic [7:0]        err_sticky;
   logic              burst_active;
   logic [4:0]        beat_cnt;
   logic [CNT_W-1:0]  wr_cnt, rd_cnt, busy_cnt;

   ahb_bus_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
      .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HRESP(HRESP), .HGRANT(HGRANT),
      .HLOCK(HLOCK), .clr_cnt(clr_cnt), .err_valid(err_valid), .err_code(err_code),
      .err_addr(err_addr), .err_sticky(err_sticky), .burst_active(burst_active),
      .beat_cnt(beat_cnt), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .busy_cnt(busy_cnt)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        v;
      logic [3:0]  code;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // One bus cycle; ec is the expected error code for this sample (0 = none)
   task automatic cyc(input logic [1:0] tr, input logic wr, input logic rdy, input logic [31:0] a,
                      input logic [2:0] sz, input logic [2:0] bu, input logic [1:0] rsp,
                      input logic [3:0] ec);
      exp_t e;
      HTRANS = tr; HWRITE = wr; HREADY = rdy; HADDR = a;
      HSIZE = sz;  HBURST = bu; HRESP = rsp;
      e.v = (ec != 4'd0); e.code = ec; e.addr = a;
      exp_q.push_back(e);
      @(posedge HCLK); #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("err_valid", 32'(err_valid), 32'(e.v));
         if (e.v) begin
            chk("err_code", 32'(err_code), 32'(e.code));
            chk("err_addr", err_addr, e.addr);
         end
      end
   endtask

   task automatic idle_cyc();
      cyc(IDLE, 1'b0, 1'b1, 32'h0, 3'd2, 3'd0, 2'd0, 4'd0);
   endtask

   task automatic do_reset();
      HRESETn = 1'b0; HTRANS = IDLE; HREADY = 1'b1; HRESP = 2'd0; clr_cnt = 1'b0;
      @(posedge HCLK); #1;
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);
      chk("rst_burst_active", 32'(burst_active), 32'd0);
      chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
      HRESETn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0; HTRANS = IDLE; HWRITE = 1'b0; HREADY = 1'b1; HADDR = '0;
      HSIZE = 3'd2; HBURST = 3'd0; HRESP = 2'd0; HGRANT = 1'b1; HLOCK = 1'b0; clr_cnt = 1'b0;

      // INCR4 write, no waits
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc((i == 0) ? NSEQ : SEQ, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 3'd2, 3'd3, 2'd0, 4'd0);
         chk("incr4_beat_cnt", 32'(beat_cnt), 32'(i + 1));
         chk("incr4_burst_active", 32'(burst_active), (i < 3) ? 32'd1 : 32'd0);
      end
      idle_cyc();
      chk("incr4_wr_cnt", 32'(wr_cnt), 32'd4);

      // WRAP4 read, good then bad 4th beat
      do_reset();
      cyc(NSEQ, 1'b0, 1'b1, 32'h38, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h3C, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h30, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h34, 3'd2, 3'd2, 2'd0, 4'd0);
      idle_cyc();
      cyc(NSEQ, 1'b0, 1'b1, 32'h38, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h3C, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h30, 3'd2, 3'd2, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h40, 3'd2, 3'd2, 2'd0, 4'd3);
      idle_cyc();
      chk("wrap_rd_cnt", 32'(rd_cnt), 32'd8);

      // Address changed during wait state
      do_reset();
      cyc(NSEQ, 1'b0, 1'b0, 32'h200, 3'd2, 3'd0, 2'd0, 4'd0);
      cyc(NSEQ, 1'b0, 1'b0, 32'h204, 3'd2, 3'd0, 2'd0, 4'd5);
      chk("wait_sticky", 32'(err_sticky), 32'h10);
      cyc(NSEQ, 1'b0, 1'b1, 32'h204, 3'd2, 3'd0, 2'd0, 4'd0);
      idle_cyc();

      // Error responses, early burst exit, oversize beat
      do_reset();
      cyc(IDLE, 1'b0, 1'b1, 32'h300, 3'd2, 3'd0, 2'd1, 4'd7);
      idle_cyc();
      cyc(NSEQ, 1'b0, 1'b1, 32'h400, 3'd2, 3'd5, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h404, 3'd2, 3'd5, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b1, 32'h408, 3'd2, 3'd5, 2'd0, 4'd0);
      cyc(SEQ,  1'b0, 1'b0, 32'h40C, 3'd2, 3'd5, 2'd1, 4'd0);
      cyc(IDLE, 1'b0, 1'b1, 32'h0,   3'd2, 3'd5, 2'd1, 4'd0);
      idle_cyc();
      cyc(NSEQ, 1'b1, 1'b1, 32'h500, 3'd2, 3'd3, 2'd0, 4'd0);
      cyc(SEQ,  1'b1, 1'b1, 32'h504, 3'd2, 3'd3, 2'd0, 4'd0);
      cyc(IDLE, 1'b1, 1'b1, 32'h508, 3'd2, 3'd3, 2'd0, 4'd6);
      HGRANT = 1'b0;
      cyc(NSEQ, 1'b1, 1'b1, 32'h500, 3'd2, 3'd3, 2'd0, 4'd0);
      cyc(IDLE, 1'b1, 1'b1, 32'h504, 3'd2, 3'd3, 2'd0, 4'd0);
      HGRANT = 1'b1;
      cyc(NSEQ, 1'b0, 1'b1, 32'h800, 3'd3, 3'd0, 2'd0, 4'd8);
      idle_cyc();

      // SEQ straight after reset also trips codes 3 and 4
      do_reset();
      cyc(SEQ, 1'b1, 1'b1, 32'h10, 3'd2, 3'd0, 2'd0, 4'd1);
      chk("seq_rst_sticky", 32'(err_sticky), 32'h0D);

      // BUSY inside an INCR burst
      do_reset();
      cyc(NSEQ, 1'b1, 1'b1, 32'h600, 3'd2, 3'd1, 2'd0, 4'd0);
      cyc(BUSY, 1'b1, 1'b1, 32'h604, 3'd2, 3'd1, 2'd0, 4'd0);
      cyc(SEQ,  1'b1, 1'b1, 32'h604, 3'd2, 3'd1, 2'd0, 4'd0);
      idle_cyc();
      chk("busy_cnt", 32'(busy_cnt), 32'd1);
      chk("busy_wr_cnt", 32'(wr_cnt), 32'd2);

      // Counter saturation and clear
      do_reset();
      for (int i = 0; i < 20; i++)
         cyc(NSEQ, 1'b0, 1'b1, 32'(i * 4), 3'd2, 3'd0, 2'd0, 4'd0);
      chk("rd_cnt_sat", 32'(rd_cnt), 32'd15);
      clr_cnt = 1'b1;
      cyc(NSEQ, 1'b0, 1'b1, 32'h80, 3'd2, 3'd0, 2'd0, 4'd0);
      clr_cnt = 1'b0;
      chk("rd_cnt_clr", 32'(rd_cnt), 32'd0);
      cyc(NSEQ, 1'b0, 1'b1, 32'h84, 3'd2, 3'd0, 2'd0, 4'd0);
      chk("rd_cnt_after_clr", 32'(rd_cnt), 32'd1);

      // Reset in the middle of an INCR16
      do_reset();
      cyc(NSEQ, 1'b1, 1'b1, 32'h700, 3'd2, 3'd7, 2'd0, 4'd0);
      cyc(SEQ,  1'b1, 1'b1, 32'h704, 3'd2, 3'd7, 2'd0, 4'd0);
      cyc(SEQ,  1'b1, 1'b1, 32'h708, 3'd2, 3'd7, 2'd0, 4'd0);
      do_reset();
      idle_cyc();
      chk("post_rst_burst_active", 32'(burst_active), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
